// File: rtl/mt_banked_reg_file.sv
// Multithreaded register file: thread-interleaved synchronous-read banks behind an in-order write buffer.
// Define MT_RF_BYPASS_EN to forward pending and same-cycle writes to reads.
module mt_banked_reg_file #(
  parameter int NUM_THREADS  = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REGS     = 32,
  parameter int NUM_BANKS    = 2,
  parameter int WB_DEPTH     = 4,
  parameter int BITS_THREADS = $clog2(NUM_THREADS),
  parameter int BITS_REGS    = $clog2(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    init_done,
  input  logic                    write_enable,
  output logic                    wr_ready,
  input  logic [BITS_THREADS-1:0] tid_write,
  input  logic [BITS_REGS-1:0]    a3,
  input  logic [DATA_WIDTH-1:0]   wd3,
  input  logic                    read_enable,
  input  logic [BITS_THREADS-1:0] tid_read,
  input  logic [BITS_REGS-1:0]    a1,
  input  logic [BITS_REGS-1:0]    a2,
  output logic                    rd_valid,
  output logic [DATA_WIDTH-1:0]   rd1,
  output logic [DATA_WIDTH-1:0]   rd2
);
  localparam int BB = $clog2(NUM_BANKS);
  localparam int D  = NUM_THREADS * NUM_REGS / NUM_BANKS;
  localparam int AW = $clog2(D);
  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;

  logic [DATA_WIDTH-1:0]   mem       [NUM_BANKS][D];
  logic [BITS_THREADS-1:0] fifo_tid  [WB_DEPTH];
  logic [BITS_REGS-1:0]    fifo_reg  [WB_DEPTH];
  logic [DATA_WIDTH-1:0]   fifo_data [WB_DEPTH];
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           count_q;

  logic                  run, full, empty, accept, enq, rd_req, drain;
  logic [BB-1:0]         rd_bank, head_bank;
  logic                  rd_valid_q, zero1_q, zero2_q;
  logic [DATA_WIDTH-1:0] bank1_q, bank2_q;

  // Bank-local address drops the tid bits that select the bank.
  function automatic logic [AW-1:0] bank_addr(input logic [BITS_THREADS-1:0] tid,
                                               input logic [BITS_REGS-1:0]    r);
    logic [BITS_THREADS+BITS_REGS-1:0] flat;
    flat = {tid >> BB, r};
    return flat[AW-1:0];
  endfunction

  assign run       = (state_q == S_RUN);
  assign init_done = run;
  assign full      = (count_q == CW'(WB_DEPTH));
  assign empty     = (count_q == '0);
  assign wr_ready  = run & ~full;
  assign accept    = write_enable & wr_ready;
  assign enq       = accept & (a3 != '0);
  assign rd_req    = read_enable & run;
  assign rd_bank   = tid_read[BB-1:0];
  assign head_bank = fifo_tid[rd_ptr_q][BB-1:0];
  // Reads own the bank; a blocked head stalls every entry behind it.
  assign drain     = run & ~empty & ~(rd_req & (rd_bank == head_bank));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == S_INIT) begin
      clr_cnt_d = clr_cnt_q + AW'(1);
      if (&clr_cnt_q) state_d = S_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_INIT;
      clr_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      zero1_q    <= 1'b1;
      zero2_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      if (enq)   wr_ptr_q <= wr_ptr_q + PW'(1);
      if (drain) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q    <= count_q + CW'(enq) - CW'(drain);
      rd_valid_q <= rd_req;
      if (rd_req) begin
        zero1_q <= (a1 == '0);
        zero2_q <= (a2 == '0);
      end
    end
  end

  // NOTE: bank and buffer storage has no reset; the clear sequence and FIFO pointers define validity.
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      for (int b = 0; b < NUM_BANKS; b++) mem[BB'(b)][clr_cnt_q] <= '0;
    end else if (drain) begin
      mem[head_bank][bank_addr(fifo_tid[rd_ptr_q], fifo_reg[rd_ptr_q])] <= fifo_data[rd_ptr_q];
    end
    if (enq) begin
      fifo_tid[wr_ptr_q]  <= tid_write;
      fifo_reg[wr_ptr_q]  <= a3;
      fifo_data[wr_ptr_q] <= wd3;
    end
    if (rd_req) begin
      bank1_q <= mem[rd_bank][bank_addr(tid_read, a1)];
      bank2_q <= mem[rd_bank][bank_addr(tid_read, a2)];
    end
  end

  assign rd_valid = rd_valid_q;

`ifdef MT_RF_BYPASS_EN
  logic                  fwd_hit1, fwd_hit2, hit1_q, hit2_q;
  logic [DATA_WIDTH-1:0] fwd_data1, fwd_data2, fwd1_q, fwd2_q;
  logic [PW-1:0]         slot;

  // Scan oldest to youngest, then the incoming write, so later matches override earlier ones.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    slot      = rd_ptr_q;
    for (int k = 0; k < WB_DEPTH; k++) begin
      slot = rd_ptr_q + PW'(k);
      if ((CW'(k) < count_q) && (fifo_tid[slot] == tid_read)) begin
        if (fifo_reg[slot] == a1) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = fifo_data[slot];
        end
        if (fifo_reg[slot] == a2) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = fifo_data[slot];
        end
      end
    end
    if (enq && (tid_write == tid_read)) begin
      if (a3 == a1) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = wd3;
      end
      if (a3 == a2) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = wd3;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit1_q <= 1'b0;
      hit2_q <= 1'b0;
      fwd1_q <= '0;
      fwd2_q <= '0;
    end else if (rd_req) begin
      hit1_q <= fwd_hit1;
      hit2_q <= fwd_hit2;
      fwd1_q <= fwd_data1;
      fwd2_q <= fwd_data2;
    end
  end

  assign rd1 = zero1_q ? '0 : (hit1_q ? fwd1_q : bank1_q);
  assign rd2 = zero2_q ? '0 : (hit2_q ? fwd2_q : bank2_q);
`else
  assign rd1 = zero1_q ? '0 : bank1_q;
  assign rd2 = zero2_q ? '0 : bank2_q;
`endif

endmodule
